// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, ID/EX bundle field offsets and the bubble constant
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam int IDEX_INSTR_LSB = 0;
  localparam int IDEX_PC4_LSB   = 32;
  localparam int IDEX_RS_LSB    = 64;
  localparam int IDEX_RT_LSB    = 96;
  localparam int IDEX_IMM_LSB   = 128;
  localparam logic [159:0] BUBBLE = 160'b0;
  function automatic logic is_load(input logic [5:0] op);
    return op == OP_LW || op == OP_LB || op == OP_LBU;
  endfunction
  function automatic logic reads_rt(input logic [5:0] op);
    return op == OP_RTYPE || op == OP_SW || op == OP_SB || op == OP_BEQ || op == OP_BNE;
  endfunction
endpackage

// File: rtl/id_ex_reg_load_use_detect.sv
// load_use_detect: flags an ID instruction that consumes the rt of a load sitting in EX
module load_use_detect
  import mips_pkg::*;
(
  input  logic [31:0] ex_instr,
  input  logic        ex_valid,
  input  logic [31:0] id_instr,
  output logic        hazard
);
  logic [4:0] ld_rt;
  logic       unused_bits;
  assign ld_rt = ex_instr[20:16];
  assign unused_bits = ^{ex_instr[25:21], ex_instr[15:0], id_instr[15:0]};
  assign hazard = ex_valid && is_load(ex_instr[31:26]) && ld_rt != 5'd0 &&
                  (ld_rt == id_instr[25:21] || (ld_rt == id_instr[20:16] && reads_rt(id_instr[31:26])));
endmodule

// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register with load-use bubble, branch flush and EX hold; optional stall counter under IDEX_STALL_CNT_EN
module id_ex_reg
  import mips_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  id_instr,
  input  logic [31:0]  id_pc4,
  input  logic [31:0]  id_rs_val,
  input  logic [31:0]  id_rt_val,
  input  logic [31:0]  id_imm,
  input  logic         ifid_valid,
  input  logic         branch_taken,
  input  logic         ex_stall,
  output logic [159:0] idex_reg,
  output logic         idex_valid,
  output logic         pc_write,
  output logic         ifid_write,
  output logic         load_use_stall
`ifdef IDEX_STALL_CNT_EN
  ,
  output logic [31:0]  stall_count
`endif
);
  logic         hazard;
  logic [159:0] nxt;
  load_use_detect u_lud (
    .ex_instr(idex_reg[31:0]),
    .ex_valid(idex_valid),
    .id_instr(id_instr),
    .hazard  (hazard)
  );
  assign load_use_stall = hazard && ifid_valid && !branch_taken;
  assign pc_write = rst || (!ex_stall && !load_use_stall);
  assign ifid_write = pc_write;
  // assemble the bundle from the ID-stage operands
  always_comb begin
    nxt = BUBBLE;
    nxt[IDEX_INSTR_LSB +: 32] = id_instr;
    nxt[IDEX_PC4_LSB +: 32] = id_pc4;
    nxt[IDEX_RS_LSB +: 32] = id_rs_val;
    nxt[IDEX_RT_LSB +: 32] = id_rt_val;
    nxt[IDEX_IMM_LSB +: 32] = id_imm;
  end
  // hold beats flush, flush and load-use both insert a bubble, else advance
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_reg <= BUBBLE;
      idex_valid <= 1'b0;
    end else if (!ex_stall) begin
      idex_reg <= (branch_taken || load_use_stall) ? BUBBLE : nxt;
      idex_valid <= (branch_taken || load_use_stall) ? 1'b0 : ifid_valid;
    end
  end
`ifdef IDEX_STALL_CNT_EN
  // count cycles in which a load-use bubble was actually inserted
  always_ff @(posedge clk) begin
    if (rst) stall_count <= 32'd0;
    else if (!ex_stall && load_use_stall) stall_count <= stall_count + 32'd1;
  end
`endif
endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: directed vectors with a scoreboard queue checked by a separate monitor
module tb_id_ex_reg;
  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  id_instr, id_pc4, id_rs_val, id_rt_val, id_imm;
  logic         ifid_valid, branch_taken, ex_stall;
  logic [159:0] idex_reg;
  logic         idex_valid, pc_write, ifid_write, load_use_stall;
`ifdef IDEX_STALL_CNT_EN
  logic [31:0]  stall_count;
`endif
  int n_vec = 0;
  int n_err = 0;
  typedef struct {
    logic         chk_luse;
    logic         luse;
    logic         pcw;
    logic [159:0] r;
    logic         v;
    string        name;
  } exp_t;
  exp_t q[$];
  logic [159:0] prev_exp = '0;
  logic [31:0]  pc = 32'h100;
  localparam logic [31:0] LW5   = 32'h8C250000;
  localparam logic [31:0] ADD6  = 32'h00A23020;
  localparam logic [31:0] SW5   = 32'hAC650004;
  localparam logic [31:0] LW0   = 32'h8C200000;
  localparam logic [31:0] ADD7  = 32'h00003820;
  localparam logic [31:0] ADDI5 = 32'h20850001;
  id_ex_reg dut (
    .clk(clk), .rst(rst), .id_instr(id_instr), .id_pc4(id_pc4),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
    .ifid_valid(ifid_valid), .branch_taken(branch_taken), .ex_stall(ex_stall),
    .idex_reg(idex_reg), .idex_valid(idex_valid), .pc_write(pc_write),
    .ifid_write(ifid_write), .load_use_stall(load_use_stall)
`ifdef IDEX_STALL_CNT_EN
    , .stall_count(stall_count)
`endif
  );
  always #5 clk = ~clk;
  // kind: 0 bubble, 1 load current inputs, 2 hold previous
  task automatic step(input string name, input logic [31:0] ins, input logic iv, br, st, r,
                      input logic cl, el, ep, input int kind, input logic ev);
    exp_t e;
    @(negedge clk);
    rst = r; id_instr = ins; id_pc4 = pc; id_rs_val = pc + 32'h1000;
    id_rt_val = pc + 32'h2000; id_imm = pc + 32'h3000;
    ifid_valid = iv; branch_taken = br; ex_stall = st;
    e.name = name; e.chk_luse = cl; e.luse = el; e.pcw = ep; e.v = ev;
    e.r = kind == 0 ? '0 : kind == 1 ? {id_imm, id_rt_val, id_rs_val, pc, ins} : prev_exp;
    prev_exp = e.r;
    q.push_back(e);
    pc = pc + 32'd4;
  endtask
  // monitor: compare combinational outputs mid-cycle, registered outputs after the edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() != 0) begin
        e = q.pop_front();
        if (e.chk_luse) begin
          n_vec++;
          if (load_use_stall !== e.luse) begin
            n_err++;
            $display("FAIL %s load_use_stall got %b want %b", e.name, load_use_stall, e.luse);
          end
        end
        n_vec++;
        if (pc_write !== e.pcw || ifid_write !== e.pcw) begin
          n_err++;
          $display("FAIL %s pc_write/ifid_write got %b/%b want %b", e.name, pc_write, ifid_write, e.pcw);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (idex_reg !== e.r || idex_valid !== e.v) begin
          n_err++;
          $display("FAIL %s idex got %h v%b want %h v%b", e.name, idex_reg, idex_valid, e.r, e.v);
        end
      end
    end
  end
  initial begin
    int t;
    rst = 1'b1; ex_stall = 1'b0; branch_taken = 1'b0; ifid_valid = 1'b0;
    id_instr = '0; id_pc4 = '0; id_rs_val = '0; id_rt_val = '0; id_imm = '0;
    step("rst0", $urandom, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    step("rst1", $urandom, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    step("lw5",        LW5,   1, 0, 0, 0, 1, 0, 1, 1, 1);
    step("add_stall",  ADD6,  1, 0, 0, 0, 1, 1, 0, 0, 0);
    step("add_enter",  ADD6,  1, 0, 0, 0, 1, 0, 1, 1, 1);
    step("lw5b",       LW5,   1, 0, 0, 0, 1, 0, 1, 1, 1);
    step("sw_stall",   SW5,   1, 0, 0, 0, 1, 1, 0, 0, 0);
    step("sw_enter",   SW5,   1, 0, 0, 0, 1, 0, 1, 1, 1);
    step("lw0",        LW0,   1, 0, 0, 0, 1, 0, 1, 1, 1);
    step("add_r0",     ADD7,  1, 0, 0, 0, 1, 0, 1, 1, 1);
    step("lw5c",       LW5,   1, 0, 0, 0, 1, 0, 1, 1, 1);
    step("addi_norT",  ADDI5, 1, 0, 0, 0, 1, 0, 1, 1, 1);
    step("lw5d",       LW5,   1, 0, 0, 0, 1, 0, 1, 1, 1);
    step("flush_haz",  ADD6,  1, 1, 0, 0, 1, 0, 1, 0, 0);
    step("lw5e",       LW5,   1, 0, 0, 0, 1, 0, 1, 1, 1);
    step("hold1",      ADD6,  1, 0, 1, 0, 1, 1, 0, 2, 1);
    step("hold2",      SW5,   1, 0, 1, 0, 1, 1, 0, 2, 1);
    step("hold3",      ADD7,  1, 1, 1, 0, 1, 0, 0, 2, 1);
    step("release",    ADD7,  1, 0, 0, 0, 1, 0, 1, 1, 1);
    step("lw_inval",   LW5,   0, 0, 0, 0, 1, 0, 1, 1, 0);
    step("no_haz_inv", ADD6,  1, 0, 0, 0, 1, 0, 1, 1, 1);
    step("lw5f",       LW5,   1, 0, 0, 0, 1, 0, 1, 1, 1);
    step("id_inval",   ADD6,  0, 0, 0, 0, 1, 0, 1, 1, 0);
`ifdef IDEX_STALL_CNT_EN
    @(negedge clk);
    n_vec++;
    if (stall_count !== 32'd2) begin
      n_err++;
      $display("FAIL stall_count got %0d want 2", stall_count);
    end
`endif
    step("lw5g",       LW5,   1, 0, 0, 0, 1, 0, 1, 1, 1);
    step("rst_stall",  ADD6,  1, 0, 1, 1, 0, 0, 1, 0, 0);
    step("after_rst",  ADD6,  1, 0, 0, 0, 1, 0, 1, 1, 1);
`ifdef IDEX_STALL_CNT_EN
    for (int i = 0; i < 5; i++) begin
      step("cnt_lw",  LW5,  1, 0, 0, 0, 1, 0, 1, 1, 1);
      step("cnt_add", ADD6, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    end
    @(negedge clk);
    n_vec++;
    if (stall_count !== 32'd5) begin
      n_err++;
      $display("FAIL stall_count5 got %0d want 5", stall_count);
    end
    step("wrap_lw", LW5, 1, 0, 0, 0, 1, 0, 1, 1, 1);
    @(negedge clk);
    force dut.stall_count = 32'hFFFFFFFF;
    #1 release dut.stall_count;
    step("wrap_add", ADD6, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    @(negedge clk);
    n_vec++;
    if (stall_count !== 32'd0) begin
      n_err++;
      $display("FAIL stall_count_wrap got %h want 00000000", stall_count);
    end
`endif
    t = 0;
    while (q.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain left %0d want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
